// File: rtl/instr_mem_ctrl_if.sv
// Fetch, boot-ROM and loader signal bundle for the instruction memory.
// Latency: none, this is wiring only.
// Backpressure: gnt_o gates fetches and ld_ready_o gates loader beats.
interface instr_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int RAM_AW = 11,
    parameter int ROM_AW = 5
);
    logic [RAM_AW:0]   addr_i;
    logic              req_i;
    logic              gnt_o;
    logic              rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;
    logic [ROM_AW-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;
    logic              ld_start_i;
    logic [RAM_AW-1:0] ld_base_i;
    logic              ld_valid_i;
    logic              ld_last_i;
    logic [DATA_W-1:0] ld_data_i;
    logic              ld_ready_o;
    logic              ld_busy_o;
    logic [RAM_AW:0]   ld_count_o;

    modport slave (
        input  addr_i, req_i, rom_data_i, ld_start_i, ld_base_i,
               ld_valid_i, ld_last_i, ld_data_i,
        output gnt_o, rvalid_o, rdata_o, err_o, rom_addr_o,
               ld_ready_o, ld_busy_o, ld_count_o
    );

    modport master (
        output addr_i, req_i, rom_data_i, ld_start_i, ld_base_i,
               ld_valid_i, ld_last_i, ld_data_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, rom_addr_o,
               ld_ready_o, ld_busy_o, ld_count_o
    );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Instruction memory: single-port RAM filled by a streaming loader, plus a boot-ROM window.
// Latency: read data appears RD_LAT cycles after the accepting edge, fully pipelined.
// Backpressure: loader and fetch share the RAM port; LOAD_PRIO picks who stalls on conflict.
module instr_mem_ctrl #(
    parameter int DATA_W    = 32,
    parameter int RAM_DEPTH = 2048,
    parameter int ROM_DEPTH = 32,
    parameter int RD_LAT    = 1,
    parameter int LOAD_PRIO = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    instr_mem_ctrl_if.slave bus
);
    localparam int              RAM_AW  = $clog2(RAM_DEPTH);
    localparam int              ROM_AW  = $clog2(ROM_DEPTH);
    localparam logic            PRIO    = (LOAD_PRIO != 0);
    localparam logic [RAM_AW:0] CNT_MAX = (RAM_AW + 1)'(RAM_DEPTH);

    typedef enum logic {S_IDLE, S_LOAD} ld_state_e;

    ld_state_e         state_q, state_d;
    logic [RAM_AW-1:0] wr_ptr_q;
    logic [RAM_AW:0]   count_q;
    logic              ld_ready, ld_busy, ld_beat, ram_we;

    logic              is_rom, fetch_err, fetch_gnt, accept;
    logic [RAM_AW-1:0] ram_idx;

    logic [DATA_W-1:0] mem [RAM_DEPTH];

    logic              pipe_vld [RD_LAT];
    logic [DATA_W-1:0] pipe_dat [RD_LAT];
    logic              pipe_err [RD_LAT];

    // Address decode: ROM window needs the bits between ROM and RAM width to be zero.
    assign is_rom    = bus.addr_i[RAM_AW];
    assign ram_idx   = bus.addr_i[RAM_AW-1:0];
    assign fetch_err = is_rom && ((ram_idx >> ROM_AW) != '0);

    // A loader beat blocks RAM fetches only when the loader has priority.
    assign ld_beat   = bus.ld_valid_i & ld_ready;
    assign ram_we    = ld_beat & rst_ni;
    assign fetch_gnt = is_rom | ~(PRIO & ld_beat);
    assign accept    = bus.req_i & fetch_gnt;

    // Loader state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Loader next state: start opens a burst, an accepted last beat closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.ld_start_i)         state_d = S_LOAD;
            S_LOAD:  if (ld_beat && bus.ld_last_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Loader outputs: with fetch priority, a RAM fetch request holds off the loader.
    always_comb begin
        ld_ready = 1'b0;
        ld_busy  = 1'b0;
        if (state_q == S_LOAD) begin
            ld_busy  = 1'b1;
            ld_ready = PRIO | ~(bus.req_i & ~is_rom);
        end
    end

    // Write pointer wraps naturally; beat count saturates at the RAM size.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (state_q == S_IDLE && bus.ld_start_i) begin
            wr_ptr_q <= bus.ld_base_i;
            count_q  <= '0;
        end else if (ld_beat) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (ram_we) mem[wr_ptr_q] <= bus.ld_data_i;
    end

    // Read pipeline: stage 0 captures the selected word, later stages only move on valid.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_dat[i] <= '0;
                pipe_err[i] <= 1'b0;
            end
        end else begin
            pipe_vld[0] <= accept;
            if (accept) begin
                pipe_err[0] <= fetch_err;
                if (fetch_err)   pipe_dat[0] <= '0;
                else if (is_rom) pipe_dat[0] <= bus.rom_data_i;
                else             pipe_dat[0] <= mem[ram_idx];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                    pipe_err[i] <= pipe_err[i-1];
                end
            end
        end
    end

    assign bus.gnt_o      = fetch_gnt;
    assign bus.rvalid_o   = pipe_vld[RD_LAT-1];
    assign bus.rdata_o    = pipe_dat[RD_LAT-1];
    assign bus.err_o      = pipe_err[RD_LAT-1];
    assign bus.rom_addr_o = bus.addr_i[ROM_AW-1:0];
    assign bus.ld_ready_o = ld_ready;
    assign bus.ld_busy_o  = ld_busy;
    assign bus.ld_count_o = count_q;
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Drives three instances (RD_LAT 1/2/3; loader priority on, on, off) with identical stimulus.
// Latency: responses are timestamped and compared against grant cycle plus RD_LAT.
// Backpressure: grant and loader-ready are compared on the conflict cycles.
module tb_instr_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] addr;
    logic        req;
    logic [31:0] rom_data;
    logic        ld_start;
    logic [10:0] ld_base;
    logic        ld_valid;
    logic        ld_last;
    logic [31:0] ld_data;

    logic        gnt      [3];
    logic        rvalid   [3];
    logic [31:0] rdata    [3];
    logic        err      [3];
    logic [4:0]  rom_addr [3];
    logic        ready    [3];
    logic        busy     [3];
    logic [11:0] cnt      [3];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    rsp_t rq0[$];
    rsp_t rq1[$];
    rsp_t rq2[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        instr_mem_ctrl_if #(.DATA_W(32), .RAM_AW(11), .ROM_AW(5)) bus ();

        assign bus.addr_i     = addr;
        assign bus.req_i      = req;
        assign bus.rom_data_i = rom_data;
        assign bus.ld_start_i = ld_start;
        assign bus.ld_base_i  = ld_base;
        assign bus.ld_valid_i = ld_valid;
        assign bus.ld_last_i  = ld_last;
        assign bus.ld_data_i  = ld_data;

        instr_mem_ctrl #(
            .DATA_W(32), .RAM_DEPTH(2048), .ROM_DEPTH(32),
            .RD_LAT(g + 1), .LOAD_PRIO((g < 2) ? 1 : 0)
        ) u_dut (
            .clk_i (clk),
            .rst_ni(rst_n),
            .bus   (bus)
        );

        assign gnt[g]      = bus.gnt_o;
        assign rvalid[g]   = bus.rvalid_o;
        assign rdata[g]    = bus.rdata_o;
        assign err[g]      = bus.err_o;
        assign rom_addr[g] = bus.rom_addr_o;
        assign ready[g]    = bus.ld_ready_o;
        assign busy[g]     = bus.ld_busy_o;
        assign cnt[g]      = bus.ld_count_o;
    end

    // Timestamp every response on the falling edge.
    always @(negedge clk) begin
        if (rvalid[0] === 1'b1) rq0.push_back({32'(cyc), err[0], rdata[0]});
        if (rvalid[1] === 1'b1) rq1.push_back({32'(cyc), err[1], rdata[1]});
        if (rvalid[2] === 1'b1) rq2.push_back({32'(cyc), err[2], rdata[2]});
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pop_chk(input int w, input string tag, input int ecyc,
                           input logic [31:0] edat, input logic eerr);
        rsp_t r;
        int   n;
        case (w)
            0:       n = rq0.size();
            1:       n = rq1.size();
            default: n = rq2.size();
        endcase
        check($sformatf("%s_d%0d_present", tag, w), 64'(n > 0), 64'd1);
        if (n > 0) begin
            case (w)
                0:       r = rq0.pop_front();
                1:       r = rq1.pop_front();
                default: r = rq2.pop_front();
            endcase
            check($sformatf("%s_d%0d_cycle", tag, w), 64'(r.cyc), 64'(ecyc));
            check($sformatf("%s_d%0d_err_dat", tag, w), 64'({r.err, r.dat}), 64'({eerr, edat}));
        end
    endtask

    task automatic expect_all(input string tag, input int g, input logic [31:0] d, input logic e);
        for (int w = 0; w < 3; w++) pop_chk(w, tag, g + w + 1, d, e);
    endtask

    task automatic fetch(input logic [11:0] a, output int g);
        addr = a;
        req  = 1'b1;
        #1;
        check("fetch_gnt", 64'({gnt[0], gnt[1], gnt[2]}), 64'(3'b111));
        g = cyc;
        tick();
        req = 1'b0;
    endtask

    task automatic load_burst(input logic [10:0] base, input int n,
                              input logic [31:0] first, input bit close);
        ld_start = 1'b1;
        ld_base  = base;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = first + 32'(i);
            ld_last  = close && (i == n - 1);
            #1;
            check("beat_ready_busy",
                  64'({ready[0], ready[1], ready[2], busy[0], busy[1], busy[2]}),
                  64'(6'b111111));
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        for (int w = 0; w < 3; w++)
            check($sformatf("%s_d%0d", tag, w),
                  64'({rvalid[w], err[w], busy[w], ready[w], cnt[w], rdata[w]}), 64'd0);
    endtask

    initial begin
        int g, g2, c1, c2;
        int gs [4];

        rst_n = 1'b0; addr = '0; req = 1'b0; rom_data = '0;
        ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        idle(2);
        check_reset_state("reset");
        rst_n = 1'b1;
        idle(1);

        // Single-beat write then fetch on the very next cycle.
        load_burst(11'd5, 1, 32'hDEADBEEF, 1'b1);
        check("t1_busy_cnt", 64'({busy[0], busy[1], busy[2], cnt[0], cnt[1], cnt[2]}),
              64'({3'b000, 12'd1, 12'd1, 12'd1}));
        fetch(12'd5, g);
        idle(5);
        expect_all("raw", g, 32'hDEADBEEF, 1'b0);

        // Back-to-back fetches with no bubbles.
        load_burst(11'd0, 4, 32'h10, 1'b1);
        for (int k = 0; k < 4; k++) fetch(12'(k), gs[k]);
        idle(5);
        for (int k = 0; k < 4; k++) expect_all($sformatf("b2b%0d", k), gs[k], 32'h10 + 32'(k), 1'b0);

        // ROM window, including an out-of-window index.
        rom_data = 32'hA5A5A5A5;
        addr = {1'b1, 11'd7};
        #1;
        check("rom_addr", 64'({rom_addr[0], rom_addr[1], rom_addr[2]}), 64'({3{5'd7}}));
        fetch({1'b1, 11'd7}, g);
        fetch({1'b1, 11'd32}, g2);
        idle(5);
        expect_all("rom", g, 32'hA5A5A5A5, 1'b0);
        expect_all("rom_err", g2, 32'h0, 1'b1);

        // Loader/fetch conflict on the RAM port.
        ld_start = 1'b1; ld_base = 11'd100;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'h77;
        req = 1'b1; addr = 12'd5;
        #1;
        check("conf_c1", 64'({gnt[0], ready[0], gnt[1], ready[1], gnt[2], ready[2]}),
              64'(6'b01_01_10));
        c1 = cyc;
        tick();
        check("conf_c2", 64'({gnt[0], ready[0], gnt[1], ready[1], gnt[2], ready[2]}),
              64'(6'b10_10_10));
        c2 = cyc;
        tick();
        req = 1'b0;
        #1;
        check("conf_c3", 64'({ready[0], ready[1], ready[2]}), 64'(3'b001));
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("conf_busy_cnt", 64'({busy[0], busy[1], busy[2], cnt[0], cnt[1], cnt[2]}),
              64'({3'b000, 12'd1, 12'd1, 12'd1}));
        idle(5);
        pop_chk(0, "conf", c2 + 1, 32'hDEADBEEF, 1'b0);
        pop_chk(1, "conf", c2 + 2, 32'hDEADBEEF, 1'b0);
        pop_chk(2, "conf_a", c1 + 3, 32'hDEADBEEF, 1'b0);
        pop_chk(2, "conf_b", c2 + 3, 32'hDEADBEEF, 1'b0);
        fetch(12'd100, g);
        idle(5);
        expect_all("conf_wr", g, 32'h77, 1'b0);

        // Burst wrapping past the top of RAM.
        load_burst(11'd2046, 4, 32'hA0, 1'b1);
        check("wrap_busy_cnt", 64'({busy[0], busy[1], busy[2], cnt[0], cnt[1], cnt[2]}),
              64'({3'b000, 12'd4, 12'd4, 12'd4}));
        fetch(12'd2046, gs[0]);
        fetch(12'd2047, gs[1]);
        fetch(12'd0, gs[2]);
        fetch(12'd1, gs[3]);
        idle(5);
        for (int k = 0; k < 4; k++) expect_all($sformatf("wrap%0d", k), gs[k], 32'hA0 + 32'(k), 1'b0);

        // Reset in the middle of a burst with fetches in flight.
        load_burst(11'd200, 2, 32'hB0, 1'b0);
        check("mid_busy", 64'({busy[0], busy[1], busy[2]}), 64'(3'b111));
        fetch(12'd2046, g);
        fetch(12'd2047, g2);
        rst_n = 1'b0;
        idle(2);
        check_reset_state("midrst");
        rst_n = 1'b1;
        idle(6);
        pop_chk(0, "fly0", g + 1, 32'hA0, 1'b0);
        pop_chk(0, "fly1", g2 + 1, 32'hA1, 1'b0);
        pop_chk(1, "fly0", g + 2, 32'hA0, 1'b0);
        check("no_rsp_after_reset", 64'(rq0.size() + rq1.size() + rq2.size()), 64'd0);
        fetch(12'd200, gs[0]);
        fetch(12'd201, gs[1]);
        fetch(12'd5, gs[2]);
        idle(5);
        expect_all("keep200", gs[0], 32'hB0, 1'b0);
        expect_all("keep201", gs[1], 32'hB1, 1'b0);
        expect_all("keep5", gs[2], 32'hDEADBEEF, 1'b0);

        check("stray_rsp", 64'(rq0.size() + rq1.size() + rq2.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised instruction memory for the core's fetch port. It holds a single-ported RAM region and an externally supplied combinational boot ROM window. A streaming loader port fills the RAM, and a configurable-latency read pipeline serves fetches. The loader arbitrates with fetch for the single RAM port, and the block flags out-of-range fetches with an error bit.

Parameters:
DATA_W, 32, instruction word width
RAM_DEPTH, 2048, RAM words (power of two); RAM_AW = clog2(RAM_DEPTH)
ROM_DEPTH, 32, ROM words (power of two, <= RAM_DEPTH); ROM_AW = clog2(ROM_DEPTH)
RD_LAT, 1, fetch read latency in cycles (legal range 1..4)
LOAD_PRIO, 1, 1 = loader wins RAM conflicts; 0 = fetch wins

Ports:
clk_i  in  1  clock, all logic on the rising edge
rst_ni  in  1  reset, synchronous, active-low
addr_i  in  RAM_AW+1  fetch word address; MSB=1 selects ROM window, MSB=0 selects RAM
req_i  in  1  fetch request
gnt_o  out  1  fetch grant (combinational)
rvalid_o  out  1  read data valid
rdata_o  out  DATA_W  read data
err_o  out  1  fetch error, qualified by rvalid_o
rom_addr_o  out  ROM_AW  ROM index, equal to addr_i[ROM_AW-1:0]
rom_data_i  in  DATA_W  combinational ROM data for rom_addr_o
ld_start_i  in  1  start a load burst
ld_base_i  in  RAM_AW  burst base word address
ld_valid_i  in  1  loader data valid
ld_last_i  in  1  marks the final beat of a burst
ld_data_i  in  DATA_W  loader data
ld_ready_o  out  1  loader beat accepted when ld_valid_i & ld_ready_o
ld_busy_o  out  1  loader FSM is in LOAD
ld_count_o  out  RAM_AW+1  beats accepted in the current or last burst

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - rvalid_o=0, rdata_o=0, err_o=0; read pipeline cleared.
  - Loader FSM goes to IDLE; ld_busy_o=0, ld_count_o=0, ld_ready_o=0.
  - RAM contents are not reset.
  - A reset in the middle of a burst or with fetches in flight discards them; no rvalid_o is issued afterwards for pre-reset requests.
- Address map:
  - ROM access: addr_i MSB=1, indexed by rom index addr_i[ROM_AW-1:0]. Bits addr_i[RAM_AW-1:ROM_AW] must be zero, otherwise the fetch is an error.
  - RAM access: addr_i MSB=0, word index addr_i[RAM_AW-1:0].
  - An error fetch still returns rvalid_o, with err_o=1 and rdata_o=0.
- Fetch pipeline:
  - A fetch is accepted when req_i & gnt_o. At most one fetch is accepted per cycle, and the pipeline is fully pipelined (no bubbles).
  - rvalid_o pulses exactly RD_LAT cycles after the accepting edge; rdata_o and err_o are valid in that same cycle.
  - rvalid_o=0 in all other cycles. rdata_o holds its last value when rvalid_o=0.
  - Read data is captured at the accepting edge, then delayed by RD_LAT-1 register stages.
- Grant:
  - gnt_o=1 for ROM fetches and error fetches.
  - For RAM fetches, gnt_o=0 only when LOAD_PRIO=1 and a loader beat is accepted in the same cycle; otherwise gnt_o=1.
  - gnt_o does not depend on req_i.
- Loader FSM:
  - IDLE:
    - ld_ready_o=0.
    - ld_start_i captures ld_base_i into the write pointer, clears ld_count_o, and moves the FSM to LOAD.
  - LOAD:
    - ld_busy_o=1.
    - ld_ready_o=1, except ld_ready_o=0 when LOAD_PRIO=0 and req_i targets RAM (MSB=0).
    - Each accepted beat writes ld_data_i to RAM[pointer], increments the pointer modulo RAM_DEPTH (wraps from RAM_DEPTH-1 to 0), and increments ld_count_o (saturates at RAM_DEPTH).
    - Accepting a beat with ld_last_i=1 returns the FSM to IDLE.
    - ld_start_i is ignored while in LOAD.
    - ld_count_o holds its value in IDLE until the next ld_start_i.
- Write/read ordering:
  - The RAM has a single port, so a write and a read never occur in the same cycle.
  - A fetch accepted the cycle after a write to the same address returns the new data.

Test Plan:
- Reset, RD_LAT=1: write 0xDEADBEEF to RAM[5] via a 1-beat burst, then fetch addr=5 -> rvalid_o one cycle after the grant, rdata_o=0xDEADBEEF, err_o=0.
- RD_LAT=3: back-to-back fetches of RAM[0..3] holding 0x10..0x13 on consecutive cycles -> four consecutive rvalid_o pulses starting 3 cycles after the first grant, data 0x10..0x13 in order.
- ROM fetch at addr={1,..0,7} with rom_data_i=0xA5A5A5A5 -> rom_addr_o=7, rdata_o=0xA5A5A5A5; addr with MSB=1 and index 32 (ROM_DEPTH=32) -> err_o=1, rdata_o=0.
- LOAD_PRIO=1, beat accepted while req_i targets RAM -> gnt_o=0 that cycle, fetch granted the next cycle. LOAD_PRIO=0, same stimulus -> ld_ready_o=0, gnt_o=1.
- Burst with base=RAM_DEPTH-2, 4 beats (last on the 4th) -> writes to 2046, 2047, 0, 1; ld_count_o=4; ld_busy_o falls after the last beat.
- rst_ni=0 mid-burst with 2 fetches in flight (RD_LAT=2) -> no rvalid_o after reset, ld_busy_o=0, ld_count_o=0, previously written RAM words still readable.
